// File: rtl/maindec_pipe.sv
// Registered MIPS main decoder for the ID/EX boundary: op/funct in, control bundle out,
// with valid/ready flow control and a HI/LO occupancy counter that stalls HI/LO users.
module maindec_pipe #(
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 32,
  parameter bit EN_MULDIV = 1'b1,
  parameter bit EN_EXT_BR = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       alusrc,
  output logic       regdst,
  output logic       regwrite,
  output logic       jump,
  output logic       link,
  output logic       jr,
  output logic       hilowrite,
  output logic       hiloread,
  output logic       muldiv_start,
  output logic       is_div,
  output logic       ri,
  output logic       hilo_busy
);

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic branch;
    logic branch_ne;
    logic alusrc;
    logic regdst;
    logic regwrite;
    logic jump;
    logic link;
    logic jr;
    logic hilowrite;
    logic hiloread;
    logic muldiv_start;
    logic is_div;
    logic ri;
  } ctrl_t;

  ctrl_t      dec;
  ctrl_t      bundle_q, bundle_d;
  logic       out_valid_q, out_valid_d;
  logic [5:0] cnt_q, cnt_d;
  logic       hazard;
  logic       accept;

  always_comb begin
    dec = '0;
    casez (op)
      6'b000000: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        case (funct)
          6'b010000, 6'b010010: dec.hiloread = 1'b1;
          6'b010001, 6'b010011: begin
            dec.regwrite  = 1'b0;
            dec.hilowrite = 1'b1;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            if (EN_MULDIV) begin
              dec.regwrite     = 1'b0;
              dec.hilowrite    = 1'b1;
              dec.muldiv_start = 1'b1;
              dec.is_div       = funct[1];
            end else begin
              dec    = '0;
              dec.ri = 1'b1;
            end
          end
          6'b001000: begin
            if (EN_EXT_BR) begin
              dec.regwrite = 1'b0;
              dec.jr       = 1'b1;
            end else begin
              dec    = '0;
              dec.ri = 1'b1;
            end
          end
          default: ;
        endcase
      end
      6'b100011: begin
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b101011: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      6'b000100: dec.branch = 1'b1;
      6'b000101: begin
        if (EN_EXT_BR) begin
          dec.branch    = 1'b1;
          dec.branch_ne = 1'b1;
        end else begin
          dec.ri = 1'b1;
        end
      end
      6'b000010: dec.jump = 1'b1;
      6'b000011: begin
        if (EN_EXT_BR) begin
          dec.jump     = 1'b1;
          dec.link     = 1'b1;
          dec.regwrite = 1'b1;
        end else begin
          dec.ri = 1'b1;
        end
      end
      6'b001???: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: dec.ri = 1'b1;
    endcase
  end

  // Handshake: a word moves in when in_valid && in_ready and out when out_valid && out_ready;
  // the held bundle stays stable while out_valid && !out_ready, and HI/LO users wait while busy.
  assign hazard   = (cnt_q != 6'd0) && (dec.hilowrite || dec.hiloread);
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A flushed mul/div never started, so it must not occupy HI/LO.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !flush && dec.muldiv_start) begin
      cnt_d = dec.is_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      cnt_q       <= 6'd0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign hilo_busy    = (cnt_q != 6'd0);
  assign memtoreg     = bundle_q.memtoreg;
  assign memwrite     = bundle_q.memwrite;
  assign branch       = bundle_q.branch;
  assign branch_ne    = bundle_q.branch_ne;
  assign alusrc       = bundle_q.alusrc;
  assign regdst       = bundle_q.regdst;
  assign regwrite     = bundle_q.regwrite;
  assign jump         = bundle_q.jump;
  assign link         = bundle_q.link;
  assign jr           = bundle_q.jr;
  assign hilowrite    = bundle_q.hilowrite;
  assign hiloread     = bundle_q.hiloread;
  assign muldiv_start = bundle_q.muldiv_start;
  assign is_div       = bundle_q.is_div;
  assign ri           = bundle_q.ri;

endmodule

// File: tb/tb_maindec_pipe.sv
// Bench for maindec_pipe: directed scenarios plus random traffic, checked each cycle
// against an instruction-level reference model with a HI/LO busy-cycle budget.
module tb_maindec_pipe;

  localparam logic [14:0] M_MEMTOREG = 15'h4000, M_MEMWRITE = 15'h2000, M_BRANCH = 15'h1000,
                          M_BNE      = 15'h0800, M_ALUSRC   = 15'h0400, M_REGDST = 15'h0200,
                          M_REGWRITE = 15'h0100, M_JUMP     = 15'h0080, M_LINK   = 15'h0040,
                          M_JR       = 15'h0020, M_HILOW    = 15'h0010, M_HILOR  = 15'h0008,
                          M_MDS      = 15'h0004, M_ISDIV    = 15'h0002, M_RI     = 15'h0001;
  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 32;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, out_ready;
  logic [5:0] op, funct;

  logic in_ready, out_valid, memtoreg, memwrite, branch, branch_ne, alusrc, regdst, regwrite;
  logic jump, link, jr, hilowrite, hiloread, muldiv_start, is_div, ri, hilo_busy;
  logic b_in_ready, b_out_valid, b_memtoreg, b_memwrite, b_branch, b_branch_ne, b_alusrc;
  logic b_regdst, b_regwrite, b_jump, b_link, b_jr, b_hilowrite, b_hiloread, b_muldiv_start;
  logic b_is_div, b_ri, b_hilo_busy;

  int total = 0;
  int bad   = 0;

  logic        m_valid;
  logic [14:0] m_bundle;
  int          m_busy;

  always #5 clk = ~clk;

  maindec_pipe #(.MUL_LAT(4), .DIV_LAT(32), .EN_MULDIV(1'b1), .EN_EXT_BR(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch), .branch_ne(branch_ne),
    .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .jump(jump), .link(link), .jr(jr),
    .hilowrite(hilowrite), .hiloread(hiloread), .muldiv_start(muldiv_start), .is_div(is_div),
    .ri(ri), .hilo_busy(hilo_busy));

  maindec_pipe #(.MUL_LAT(4), .DIV_LAT(32), .EN_MULDIV(1'b0), .EN_EXT_BR(1'b0)) u_dut_min (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .op(op), .funct(funct), .out_valid(b_out_valid), .out_ready(out_ready),
    .memtoreg(b_memtoreg), .memwrite(b_memwrite), .branch(b_branch), .branch_ne(b_branch_ne),
    .alusrc(b_alusrc), .regdst(b_regdst), .regwrite(b_regwrite), .jump(b_jump), .link(b_link),
    .jr(b_jr), .hilowrite(b_hilowrite), .hiloread(b_hiloread), .muldiv_start(b_muldiv_start),
    .is_div(b_is_div), .ri(b_ri), .hilo_busy(b_hilo_busy));

  function automatic logic [14:0] obs_main();
    return {memtoreg, memwrite, branch, branch_ne, alusrc, regdst, regwrite, jump, link, jr,
            hilowrite, hiloread, muldiv_start, is_div, ri};
  endfunction

  function automatic logic [14:0] obs_min();
    return {b_memtoreg, b_memwrite, b_branch, b_branch_ne, b_alusrc, b_regdst, b_regwrite,
            b_jump, b_link, b_jr, b_hilowrite, b_hiloread, b_muldiv_start, b_is_div, b_ri};
  endfunction

  // Instruction-level meaning of each op/funct, as a set of control flags.
  function automatic logic [14:0] ref_dec(input logic [5:0] o, input logic [5:0] f,
                                          input bit emd, input bit ebr);
    logic [14:0] r;
    bit is_md, is_mt, is_mf, is_jr;
    is_md = (o == 6'h00) && (f == 6'h18 || f == 6'h19 || f == 6'h1a || f == 6'h1b);
    is_mt = (o == 6'h00) && (f == 6'h11 || f == 6'h13);
    is_mf = (o == 6'h00) && (f == 6'h10 || f == 6'h12);
    is_jr = (o == 6'h00) && (f == 6'h08);
    if (o == 6'h00) begin
      if ((is_md && !emd) || (is_jr && !ebr)) return M_RI;
      r = M_REGDST;
      if (!(is_md || is_mt || is_jr)) r = r | M_REGWRITE;
      if (is_md || is_mt) r = r | M_HILOW;
      if (is_mf) r = r | M_HILOR;
      if (is_md) r = r | M_MDS;
      if (is_md && (f == 6'h1a || f == 6'h1b)) r = r | M_ISDIV;
      if (is_jr) r = r | M_JR;
      return r;
    end
    if (o == 6'h23) return M_MEMTOREG | M_ALUSRC | M_REGWRITE;
    if (o == 6'h2b) return M_MEMWRITE | M_ALUSRC;
    if (o == 6'h04) return M_BRANCH;
    if (o == 6'h05) return ebr ? (M_BRANCH | M_BNE) : M_RI;
    if (o == 6'h02) return M_JUMP;
    if (o == 6'h03) return ebr ? (M_JUMP | M_LINK | M_REGWRITE) : M_RI;
    if (o >= 6'h08 && o <= 6'h0f) return M_ALUSRC | M_REGWRITE;
    return M_RI;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic r, input logic fl);
    in_valid  = v;
    op        = o;
    funct     = f;
    out_ready = r;
    flush     = fl;
    #1;
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_bundle = '0;
    m_busy   = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic [14:0] d;
    logic        rdy, acc;
    @(negedge clk);
    d   = ref_dec(op, funct, 1'b1, 1'b1);
    rdy = (!m_valid || out_ready) && !(m_busy > 0 && (d & (M_HILOW | M_HILOR)) != 15'd0);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_valid);
    chk("hilo_busy", hilo_busy, m_busy > 0);
    if (m_valid) chk("bundle", obs_main(), m_bundle);
    @(posedge clk);
    acc = in_valid && rdy;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid  = 1'b1;
      m_bundle = d;
    end else if (out_ready) m_valid = 1'b0;
    if (acc && !flush && (d & M_MDS) != 15'd0) m_busy = ((d & M_ISDIV) != 15'd0) ? DIV_CYC : MUL_CYC;
    else if (m_busy > 0) m_busy--;
    #1;
  endtask

  initial begin
    int n_busy, mflo_at;
    logic lw_ok, done;
    logic [5:0] ops[12];
    logic [5:0] fns[12];
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h09, 6'h3f, 6'h1c};
    fns = '{6'h20, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h08, 6'h2a, 6'h3e};

    resetn = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    model_reset();
    #10;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bundle", obs_main(), 15'd0);
    chk("rst_hilo_busy", hilo_busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // ADDIU, then R-type ADD and MTHI
    drive(1'b1, 6'h09, 6'h00, 1'b1, 1'b0);
    cycle();
    chk("addiu_valid", out_valid, 1'b1);
    chk("addiu_alusrc", alusrc, 1'b1);
    chk("addiu_regwrite", regwrite, 1'b1);
    chk("addiu_regdst", regdst, 1'b0);
    chk("addiu_ri", ri, 1'b0);
    drive(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    cycle();
    chk("add_ctrl", {regdst, regwrite, hilowrite}, 3'b110);
    drive(1'b1, 6'h00, 6'h11, 1'b1, 1'b0);
    cycle();
    chk("mthi_ctrl", {regwrite, hilowrite}, 2'b01);

    // DIV then MFLO stalls; an LW slips through during the busy window
    drive(1'b1, 6'h00, 6'h1a, 1'b1, 1'b0);
    cycle();
    n_busy = 0; mflo_at = -1; lw_ok = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (hilo_busy) n_busy++;
      if (i == 10) begin
        drive(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
        lw_ok = in_ready;
      end else begin
        drive(1'b1, 6'h00, 6'h12, 1'b1, 1'b0);
        if (in_ready) begin
          done    = 1'b1;
          mflo_at = i;
        end
      end
      cycle();
    end
    chk("div_busy_cycles", n_busy, DIV_CYC);
    chk("lw_in_window", lw_ok, 1'b1);
    chk("mflo_first_free", mflo_at, DIV_CYC);
    chk("mflo_hiloread", hiloread, 1'b1);

    // Backpressure with BEQ held
    drive(1'b1, 6'h04, 6'h00, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_branch", branch, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      cycle();
    end
    drive(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    cycle();
    chk("after_hold_add", {branch, regdst, regwrite}, 3'b011);

    // Reserved opcode; MULT and JAL on the reduced-feature instance
    drive(1'b1, 6'h3f, 6'h00, 1'b1, 1'b0);
    cycle();
    chk("op3f_ri_only", obs_main(), M_RI);
    drive(1'b1, 6'h00, 6'h18, 1'b1, 1'b0);
    cycle();
    chk("min_mult_ri", obs_min(), M_RI);
    chk("min_mult_busy", b_hilo_busy, 1'b0);
    drive(1'b1, 6'h03, 6'h00, 1'b1, 1'b0);
    cycle();
    chk("min_jal_ri", obs_min(), M_RI);
    chk("main_jal", obs_main(), M_JUMP | M_LINK | M_REGWRITE);
    drive(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    repeat (5) cycle();

    // Flush alongside an accepted DIV
    drive(1'b1, 6'h00, 6'h1a, 1'b1, 1'b1);
    chk("flush_div_in_ready", in_ready, 1'b1);
    cycle();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_hilo_busy", hilo_busy, 1'b0);

    // Asynchronous reset in the middle of a divide
    drive(1'b1, 6'h00, 6'h1a, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    repeat (3) cycle();
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_hilo_busy", hilo_busy, 1'b0);
    chk("areset_out_valid", out_valid, 1'b0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)],
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)],
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
